add_burst_accumulator: RTL and testbench

Downstream consumer of the 8-bit registered `adder`. It collects the adder's 9-bit results `{cout, sum}` over a fixed-length burst and sums them into a wide accumulator. When a burst completes, it presents the total on a valid/ready output. A delayed valid pipe inside the block tracks the adder's fixed pipeline latency, so upstream only has to flag each operand pair it issues.

---
 rtl/adder_pkg.sv | 11 +
 rtl/add_burst_accumulator_if.sv | 24 ++
 rtl/add_burst_accumulator_valid_delay.sv | 27 ++
 rtl/add_burst_accumulator.sv | 124 ++++++++++++
 tb/tb_add_burst_accumulator.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants and state type for the adder and its burst accumulator.
package adder_pkg;
    localparam int ADD_W   = 8;
    localparam int RES_W   = 9;
    localparam int ADD_LAT = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;
endpackage

// File: rtl/add_burst_accumulator_if.sv
// Bundles the adder-result input side and the total output handshake of the accumulator.
interface add_burst_accumulator_if import adder_pkg::*; #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic [ADD_W-1:0] sum;
    logic             cout;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_total;
    logic             out_ovf;
    logic             busy;
    logic             drop;

    modport master (
        output in_valid, sum, cout, out_ready,
        input  out_valid, out_total, out_ovf, busy, drop
    );

    modport slave (
        input  in_valid, sum, cout, out_ready,
        output out_valid, out_total, out_ovf, busy, drop
    );
endinterface

// File: rtl/add_burst_accumulator_valid_delay.sv
// Shift-register valid pipe matching the adder latency; also flags any result in flight.
module valid_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic res_valid,
    output logic any_valid
);
    logic [LAT-1:0] pipe_r;

    // Advance the valid flags one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_r <= {LAT{1'b0}};
        end else begin
            pipe_r[0] <= in_valid;
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign res_valid = pipe_r[LAT-1];
    assign any_valid = |pipe_r;
endmodule

// File: rtl/add_burst_accumulator.sv
// Sums BURST adder results into a wide total presented on a valid/ready output.
// Define ACC_SAT_EN to clamp the accumulator at all-ones on overflow instead of wrapping.
module add_burst_accumulator import adder_pkg::*; #(
    parameter int ACC_W = 16,
    parameter int LAT   = ADD_LAT,
    parameter int BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    add_burst_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

    acc_state_t       state_r, state_nxt_s;
    logic [ACC_W-1:0] acc_r, acc_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             sticky_ovf_r, sticky_ovf_nxt_s;
    logic             res_valid_s, pipe_busy_s;
    logic [ACC_W:0]   r_s, sum_s;
    logic [ACC_W-1:0] total_s;
    logic             total_ovf_s, carry_s, complete_s;
    logic             out_valid_r, out_ovf_r, drop_r;
    logic [ACC_W-1:0] out_total_r;

    valid_delay #(.LAT(LAT)) u_valid_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .res_valid (res_valid_s),
        .any_valid (pipe_busy_s)
    );

    assign r_s     = {{(ACC_W + 1 - RES_W){1'b0}}, bus.cout, bus.sum};
    assign sum_s   = {1'b0, acc_r} + r_s;
    assign carry_s = sum_s[ACC_W];
`ifdef ACC_SAT_EN
    // Once clamped, every further add carries again, so the clamp holds for the burst.
    assign total_s = carry_s ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
`else
    assign total_s = sum_s[ACC_W-1:0];
`endif
    assign total_ovf_s = sticky_ovf_r | carry_s;
    assign complete_s  = res_valid_s && (cnt_r == LAST_CNT);

    // Accumulation state, running sum, result count and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            sticky_ovf_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            acc_r        <= acc_nxt_s;
            cnt_r        <= cnt_nxt_s;
            sticky_ovf_r <= sticky_ovf_nxt_s;
        end
    end

    // Next-state logic: add each result, clear back to IDLE on the completing one.
    always_comb begin
        state_nxt_s      = state_r;
        acc_nxt_s        = acc_r;
        cnt_nxt_s        = cnt_r;
        sticky_ovf_nxt_s = sticky_ovf_r;
        case (state_r)
            IDLE, ACCUM: begin
                if (res_valid_s) begin
                    if (complete_s) begin
                        state_nxt_s      = IDLE;
                        acc_nxt_s        = {ACC_W{1'b0}};
                        cnt_nxt_s        = {CNT_W{1'b0}};
                        sticky_ovf_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s      = ACCUM;
                        acc_nxt_s        = total_s;
                        cnt_nxt_s        = cnt_r + CNT_W'(1);
                        sticky_ovf_nxt_s = total_ovf_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                acc_nxt_s        = {ACC_W{1'b0}};
                cnt_nxt_s        = {CNT_W{1'b0}};
                sticky_ovf_nxt_s = 1'b0;
            end
        endcase
    end

    // Output holding register: a total arriving while one is stuck is discarded and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_total_r <= {ACC_W{1'b0}};
            out_ovf_r   <= 1'b0;
            drop_r      <= 1'b0;
        end else begin
            drop_r <= 1'b0;
            if (complete_s) begin
                if (!out_valid_r || bus.out_ready) begin
                    out_valid_r <= 1'b1;
                    out_total_r <= total_s;
                    out_ovf_r   <= total_ovf_s;
                end else begin
                    drop_r <= 1'b1;
                end
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_total = out_total_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.drop      = drop_r;
    assign bus.busy      = (state_r == ACCUM) || pipe_busy_s;
endmodule

// File: tb/tb_add_burst_accumulator.sv
// Scoreboard bench: a BURST=4/ACC_W=10 instance and a BURST=1/ACC_W=16 instance fed by adder models.
module tb_add_burst_accumulator;
    import adder_pkg::*;

    localparam int W0 = 10;
    localparam int B0 = 4;
    localparam int W1 = 16;
    localparam int B1 = 1;

    typedef struct {
        longint total;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add_burst_accumulator_if #(.ACC_W(W0)) bus0 ();
    add_burst_accumulator_if #(.ACC_W(W1)) bus1 ();

    add_burst_accumulator #(.ACC_W(W0), .LAT(ADD_LAT), .BURST(B0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave)
    );
    add_burst_accumulator #(.ACC_W(W1), .LAT(ADD_LAT), .BURST(B1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave)
    );

    // Registered 8-bit adder models with two cycles of latency.
    logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
    logic [8:0] p0_1 = 9'd0, p0_2 = 9'd0, p1_1 = 9'd0, p1_2 = 9'd0;
    always @(posedge clk) begin
        p0_1 <= {1'b0, a0} + {1'b0, b0};
        p0_2 <= p0_1;
        p1_1 <= {1'b0, a1} + {1'b0, b1};
        p1_2 <= p1_1;
    end
    assign {bus0.cout, bus0.sum} = p0_2;
    assign {bus1.cout, bus1.sum} = p1_2;

    exp_t   q0[$], q1[$];
    exp_t   e0, e1;
    longint part0 = 0, part1 = 0;
    int     cnt0 = 0, cnt1 = 0;
    int     total_n = 0, bad_n = 0;
    int     drops0 = 0, drops1 = 0;
    longint last_total0 = -1, last_total1 = -1;
    bit     last_ovf0 = 1'b0;

    function automatic exp_t mk(input longint s, input int w);
        exp_t   e;
        longint maxv;
        maxv  = (longint'(1) << w) - 1;
        e.ovf = (s > maxv);
`ifdef ACC_SAT_EN
        e.total = e.ovf ? maxv : s;
`else
        e.total = s % (maxv + 1);
`endif
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total_n++;
        if (act != exp) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step0(input bit v, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        bus0.in_valid = v;
        a0 = a;
        b0 = b;
        if (v) begin
            part0 += longint'(a) + longint'(b);
            cnt0++;
            if (cnt0 == B0) begin
                q0.push_back(mk(part0, W0));
                part0 = 0;
                cnt0  = 0;
            end
        end
    endtask

    task automatic step1(input bit v, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        bus1.in_valid = v;
        a1 = a;
        b1 = b;
        if (v) begin
            part1 += longint'(a) + longint'(b);
            cnt1++;
            if (cnt1 == B1) begin
                q1.push_back(mk(part1, W1));
                part1 = 0;
                cnt1  = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus0.in_valid = 1'b0;
            bus1.in_valid = 1'b0;
        end
    endtask

    // Monitor for instance 0: drop removes the discarded total, a transfer pops and compares.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.drop) begin
                drops0++;
                if (q0.size() < 2) begin
                    total_n++; bad_n++;
                    $display("FAIL drop0: drop with %0d totals queued, need at least 2", q0.size());
                end else begin
                    q0.delete(1);
                end
            end
            if (bus0.out_valid && bus0.out_ready) begin
                total_n++;
                last_total0 = longint'(bus0.out_total);
                last_ovf0   = bus0.out_ovf;
                if (q0.size() == 0) begin
                    bad_n++;
                    $display("FAIL out0: unexpected total %0d, none expected", bus0.out_total);
                end else begin
                    e0 = q0.pop_front();
                    if (longint'(bus0.out_total) != e0.total || bus0.out_ovf != e0.ovf) begin
                        bad_n++;
                        $display("FAIL out0: got total=%0d ovf=%0b expected total=%0d ovf=%0b",
                                 bus0.out_total, bus0.out_ovf, e0.total, e0.ovf);
                    end
                end
            end
        end
    end

    // Monitor for instance 1, same scheme.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.drop) begin
                drops1++;
                if (q1.size() < 2) begin
                    total_n++; bad_n++;
                    $display("FAIL drop1: drop with %0d totals queued, need at least 2", q1.size());
                end else begin
                    q1.delete(1);
                end
            end
            if (bus1.out_valid && bus1.out_ready) begin
                total_n++;
                last_total1 = longint'(bus1.out_total);
                if (q1.size() == 0) begin
                    bad_n++;
                    $display("FAIL out1: unexpected total %0d, none expected", bus1.out_total);
                end else begin
                    e1 = q1.pop_front();
                    if (longint'(bus1.out_total) != e1.total || bus1.out_ovf != e1.ovf) begin
                        bad_n++;
                        $display("FAIL out1: got total=%0d ovf=%0b expected total=%0d ovf=%0b",
                                 bus1.out_total, bus1.out_ovf, e1.total, e1.ovf);
                    end
                end
            end
        end
    end

    logic [7:0] pa [4];
    logic [7:0] pb [4];
    int         lat;
    int         d0;

    initial begin
        pa = '{8'd10, 8'd100, 8'd255, 8'd255};
        pb = '{8'd20, 8'd100, 8'd1, 8'd255};
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;

        #12;
        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_out_total", bus0.out_total, 0);
        chk("rst_out_ovf", bus0.out_ovf, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_drop", bus0.drop, 0);
        chk("rst_out_valid1", bus1.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic back-to-back burst and output latency.
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step0(1'b1, pa[i], pb[i]);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            bus0.in_valid = 1'b0;
            if (bus0.out_valid && lat == 0) lat = k;
        end
        chk("latency", lat, ADD_LAT + 1);
        chk("basic_total", last_total0, 996);
        chk("basic_ovf", last_ovf0, 0);

        // Same pairs with three idle cycles between them; busy must hold.
        for (int i = 0; i < 4; i++) begin
            step0(1'b1, pa[i], pb[i]);
            if (i > 0) chk("bubble_busy", bus0.busy, 1);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    step0(1'b0, 8'd0, 8'd0);
                    chk("bubble_busy", bus0.busy, 1);
                end
            end
        end
        idle(8);
        chk("bubble_total", last_total0, 996);
        chk("busy_after", bus0.busy, 0);

        // Overflow at ACC_W=10.
        for (int i = 0; i < 4; i++) step0(1'b1, 8'd255, 8'd255);
        idle(8);
`ifdef ACC_SAT_EN
        chk("ovf_total", last_total0, 1023);
`else
        chk("ovf_total", last_total0, 1016);
`endif
        chk("ovf_flag", last_ovf0, 1);

        // Backpressure on the BURST=1 instance.
        d0 = drops1;
        step1(1'b1, 8'd11, 8'd22);
        step1(1'b1, 8'd40, 8'd50);
        idle(6);
        chk("bp_drops", drops1 - d0, 1);
        chk("bp_held_valid", bus1.out_valid, 1);
        chk("bp_held_total", bus1.out_total, 33);
        step1(1'b1, 8'd7, 8'd8);
        step1(1'b0, 8'd0, 8'd0);
        @(posedge clk); #1;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        chk("bp_replace_valid", bus1.out_valid, 1);
        chk("bp_replace_total", bus1.out_total, 15);
        idle(2);
        chk("bp_stable_total", bus1.out_total, 15);
        bus1.out_ready = 1'b1;
        idle(3);
        chk("bp_last_xfer", last_total1, 15);
        chk("bp_drops_final", drops1 - d0, 1);

        // Reset mid-burst with an output still pending on instance 0.
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step0(1'b1, 8'd9, 8'd1);
        step0(1'b1, 8'd50, 8'd60);
        step0(1'b1, 8'd70, 8'd80);
        idle(4);
        chk("pre_rst_valid", bus0.out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", bus0.out_valid, 0);
        chk("mid_rst_total", bus0.out_total, 0);
        chk("mid_rst_ovf", bus0.out_ovf, 0);
        chk("mid_rst_busy", bus0.busy, 0);
        chk("mid_rst_drop", bus0.drop, 0);
        @(negedge clk);
        rst = 1'b0;
        q0.delete(); q1.delete();
        part0 = 0; cnt0 = 0; part1 = 0; cnt1 = 0;
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step0(1'b1, 8'(2 * i + 1), 8'(2 * i + 2));
        idle(8);
        chk("post_rst_total", last_total0, 36);

        // Randomized traffic with random backpressure on instance 0.
        for (int n = 0; n < 40; ) begin
            bus0.out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                step0(1'b0, 8'd0, 8'd0);
            end else begin
                step0(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                n++;
            end
        end
        bus0.out_ready = 1'b1;
        idle(10);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
